// File: rtl/reset_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, cause bit
// positions (also used by the status/register block) and counter sizing.
package reset_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    localparam int CAUSE_W   = 3;
    localparam int CAUSE_PLL = 0;
    localparam int CAUSE_EXT = 1;
    localparam int CAUSE_SW  = 2;

    // Counter width for a count of n cycles; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_debounce.sv
// Two-flop synchronizer plus stability counter: the output level only follows
// the synchronized input after DEBOUNCE_CYC consecutive differing samples.
module reset_debounce
    import reset_seq_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             deb_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Reset value 0 means the button reset reads as asserted until proven stable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            deb_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= i_async;
            sync2_reg <= sync1_reg;
            if (sync2_reg == deb_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
                deb_reg <= sync2_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign o_level = deb_reg;

endmodule

// File: rtl/reset_seq_ctrl.sv
// Central reset sequencer: merges PLL lock, debounced button and software reset
// into one request, holds reset for HOLD_CYC, then releases stages in order.
module reset_seq_ctrl
    import reset_seq_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = 3,
    parameter int DEBOUNCE_CYC = 16,
    parameter int HOLD_CYC     = 64,
    parameter int STAGE_GAP    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_pll_locked,
    input  logic                  i_ext_rst_n,
    input  logic                  i_sw_rst,
    output logic [NUM_STAGES-1:0] o_rst_n_stage,
    output logic                  o_rst_busy,
    output logic [CAUSE_W-1:0]    o_rst_cause
);

    localparam int HOLD_W = cnt_width(HOLD_CYC);
    localparam int GAP_W  = cnt_width(STAGE_GAP);

    logic                  pll_meta_reg;
    logic                  pll_sync_reg;
    logic                  ext_deb;
    logic                  req;
    logic                  enter_assert;
    state_e                state_reg, state_next;
    logic [HOLD_W-1:0]     hold_cnt_reg, hold_cnt_next;
    logic [GAP_W-1:0]      gap_cnt_reg, gap_cnt_next;
    logic [NUM_STAGES-1:0] stage_reg, stage_next, stage_shift;
    logic [CAUSE_W-1:0]    cause_reg, cause_next;

    reset_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ext_deb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_ext_rst_n),
        .o_level (ext_deb)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pll_meta_reg <= 1'b0;
            pll_sync_reg <= 1'b0;
        end else begin
            pll_meta_reg <= i_pll_locked;
            pll_sync_reg <= pll_meta_reg;
        end
    end

    assign req         = ~pll_sync_reg | ~ext_deb | i_sw_rst;
    assign stage_shift = (stage_reg << 1) | NUM_STAGES'(1);

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        stage_next    = stage_reg;
        cause_next    = cause_reg;
        enter_assert  = 1'b0;

        case (state_reg)
            ST_ASSERT: begin
                stage_next = '0;
                if (!req) begin
                    state_next    = ST_HOLD;
                    hold_cnt_next = '0;
                end
            end
            ST_HOLD: begin
                // A request on the wrap cycle wins over the release.
                if (req) begin
                    enter_assert = 1'b1;
                end else if (hold_cnt_reg == HOLD_W'(HOLD_CYC - 1)) begin
                    stage_next   = NUM_STAGES'(1);
                    gap_cnt_next = '0;
                    state_next   = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (req) begin
                    enter_assert = 1'b1;
                end else if (gap_cnt_reg == GAP_W'(STAGE_GAP - 1)) begin
                    gap_cnt_next = '0;
                    stage_next   = stage_shift;
                    if (&stage_shift) begin
                        state_next = ST_RUN;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            ST_RUN: begin
                if (req) begin
                    enter_assert = 1'b1;
                end
            end
            default: begin
                enter_assert = 1'b1;
            end
        endcase

        // Cause is latched only on entry, so requests while already in ASSERT keep it.
        if (enter_assert) begin
            state_next            = ST_ASSERT;
            stage_next            = '0;
            hold_cnt_next         = '0;
            gap_cnt_next          = '0;
            cause_next[CAUSE_SW]  = i_sw_rst;
            cause_next[CAUSE_EXT] = ~ext_deb;
            cause_next[CAUSE_PLL] = ~pll_sync_reg;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_ASSERT;
            hold_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            stage_reg    <= '0;
            cause_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            stage_reg    <= stage_next;
            cause_reg    <= cause_next;
        end
    end

    assign o_rst_n_stage = stage_reg;
    assign o_rst_busy    = (state_reg != ST_RUN);
    assign o_rst_cause   = cause_reg;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl at default parameters; cycle numbers are
// counted in rising edges after the stimulus change, outputs sampled on falling edges.
module tb_reset_seq_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll   = 1'b0;
    logic       ext   = 1'b0;
    logic       sw    = 1'b0;
    logic [2:0] stage;
    logic       busy;
    logic [2:0] cause;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    int rise_at [3];
    int zero_at;
    int busy_fall_at;
    logic       mono_bad;
    logic [2:0] prev_stage;
    logic       prev_busy;

    reset_seq_ctrl #(
        .NUM_STAGES   (3),
        .DEBOUNCE_CYC (16),
        .HOLD_CYC     (64),
        .STAGE_GAP    (8)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pll_locked  (pll),
        .i_ext_rst_n   (ext),
        .i_sw_rst      (sw),
        .o_rst_n_stage (stage),
        .o_rst_busy    (busy),
        .o_rst_cause   (cause)
    );

    always #5 clk = ~clk;

    task automatic clear_rec();
        cyc          = 0;
        zero_at      = -1;
        busy_fall_at = -1;
        mono_bad     = 1'b0;
        prev_stage   = stage;
        prev_busy    = busy;
        for (int s = 0; s < 3; s++) rise_at[s] = -1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int s = 0; s < 3; s++)
            if (rise_at[s] < 0 && stage[s] && !prev_stage[s]) rise_at[s] = cyc;
        if (zero_at < 0 && stage == 3'b000 && prev_stage != 3'b000) zero_at = cyc;
        if (busy_fall_at < 0 && !busy && prev_busy) busy_fall_at = cyc;
        if ((stage[1] && !stage[0]) || (stage[2] && !stage[1])) mono_bad = 1'b1;
        prev_stage = stage;
        prev_busy  = busy;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pll = 1'b1; ext = 1'b1; sw = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (stage !== 3'b000) begin n_err++; $display("FAIL reset_stage: got %b expected 000", stage); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b expected 1", busy); end
        n_cmp++; if (cause !== 3'b000) begin n_err++; $display("FAIL reset_cause: got %b expected 000", cause); end
        $display("test_reset: stage=%b busy=%b cause=%b", stage, busy, cause);
    endtask

    task automatic test_power_on();
        rst_n = 1'b1;
        clear_rec();
        run(110);
        n_cmp++; if (rise_at[0] != 83) begin n_err++; $display("FAIL por_stage0_rise: got %0d expected 83", rise_at[0]); end
        n_cmp++; if (rise_at[1] != 91) begin n_err++; $display("FAIL por_stage1_rise: got %0d expected 91", rise_at[1]); end
        n_cmp++; if (rise_at[2] != 99) begin n_err++; $display("FAIL por_stage2_rise: got %0d expected 99", rise_at[2]); end
        n_cmp++; if (busy_fall_at != 99) begin n_err++; $display("FAIL por_busy_fall: got %0d expected 99", busy_fall_at); end
        n_cmp++; if (cause !== 3'b000) begin n_err++; $display("FAIL por_cause: got %b expected 000", cause); end
        n_cmp++; if (stage !== 3'b111) begin n_err++; $display("FAIL por_final_stage: got %b expected 111", stage); end
        n_cmp++; if (mono_bad !== 1'b0) begin n_err++; $display("FAIL por_monotonic: got %b expected 0", mono_bad); end
        $display("test_power_on: rise=%0d/%0d/%0d busy_fall=%0d", rise_at[0], rise_at[1], rise_at[2], busy_fall_at);
    endtask

    task automatic test_sw_reset();
        sw = 1'b1;
        clear_rec();
        step();
        sw = 1'b0;
        n_cmp++; if (stage !== 3'b000) begin n_err++; $display("FAIL sw_stage_drop: got %b expected 000", stage); end
        n_cmp++; if (cause !== 3'b100) begin n_err++; $display("FAIL sw_cause: got %b expected 100", cause); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL sw_busy: got %b expected 1", busy); end
        run(90);
        n_cmp++; if (rise_at[0] != 66) begin n_err++; $display("FAIL sw_stage0_rise: got %0d expected 66", rise_at[0]); end
        n_cmp++; if (rise_at[1] != 74) begin n_err++; $display("FAIL sw_stage1_rise: got %0d expected 74", rise_at[1]); end
        n_cmp++; if (rise_at[2] != 82) begin n_err++; $display("FAIL sw_stage2_rise: got %0d expected 82", rise_at[2]); end
        n_cmp++; if (mono_bad !== 1'b0) begin n_err++; $display("FAIL sw_monotonic: got %b expected 0", mono_bad); end
        $display("test_sw_reset: rise=%0d/%0d/%0d cause=%b", rise_at[0], rise_at[1], rise_at[2], cause);
    endtask

    task automatic test_glitch();
        ext = 1'b0;
        clear_rec();
        run(10);
        ext = 1'b1;
        run(30);
        n_cmp++; if (zero_at != -1) begin n_err++; $display("FAIL glitch_no_reset: got drop at %0d expected none (-1)", zero_at); end
        n_cmp++; if (stage !== 3'b111) begin n_err++; $display("FAIL glitch_stage: got %b expected 111", stage); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b expected 0", busy); end
        $display("test_glitch: stage=%b busy=%b", stage, busy);
    endtask

    task automatic test_ext_reset();
        ext = 1'b0;
        clear_rec();
        run(20);
        ext = 1'b1;
        run(110);
        n_cmp++; if (zero_at != 19) begin n_err++; $display("FAIL ext_drop: got %0d expected 19", zero_at); end
        n_cmp++; if (cause !== 3'b010) begin n_err++; $display("FAIL ext_cause: got %b expected 010", cause); end
        n_cmp++; if (rise_at[0] != 103) begin n_err++; $display("FAIL ext_stage0_rise: got %0d expected 103", rise_at[0]); end
        n_cmp++; if (rise_at[2] != 119) begin n_err++; $display("FAIL ext_stage2_rise: got %0d expected 119", rise_at[2]); end
        $display("test_ext_reset: drop=%0d rise0=%0d rise2=%0d cause=%b", zero_at, rise_at[0], rise_at[2], cause);
    endtask

    task automatic test_pll_drop();
        sw = 1'b1;
        clear_rec();
        step();
        sw = 1'b0;
        for (int i = 0; i < 100 && !stage[0]; i++) step();
        n_cmp++; if (rise_at[0] != 66) begin n_err++; $display("FAIL pll_pre_stage0: got %0d expected 66", rise_at[0]); end
        n_cmp++; if (stage !== 3'b001) begin n_err++; $display("FAIL pll_pre_stage: got %b expected 001", stage); end
        pll = 1'b0;
        clear_rec();
        run(3);
        n_cmp++; if (zero_at != 3) begin n_err++; $display("FAIL pll_drop: got %0d expected 3", zero_at); end
        n_cmp++; if (cause !== 3'b001) begin n_err++; $display("FAIL pll_cause: got %b expected 001", cause); end
        sw = 1'b1;
        step();
        sw = 1'b0;
        n_cmp++; if (cause !== 3'b001) begin n_err++; $display("FAIL sw_in_assert_cause: got %b expected 001", cause); end
        pll = 1'b1;
        run(90);
        n_cmp++; if (rise_at[0] != 71) begin n_err++; $display("FAIL relock_stage0: got %0d expected 71", rise_at[0]); end
        n_cmp++; if (rise_at[1] != 79) begin n_err++; $display("FAIL relock_stage1: got %0d expected 79", rise_at[1]); end
        n_cmp++; if (rise_at[2] != 87) begin n_err++; $display("FAIL relock_stage2: got %0d expected 87", rise_at[2]); end
        n_cmp++; if (mono_bad !== 1'b0) begin n_err++; $display("FAIL relock_monotonic: got %b expected 0", mono_bad); end
        $display("test_pll_drop: drop=%0d relock rise=%0d/%0d/%0d cause=%b", zero_at, rise_at[0], rise_at[1], rise_at[2], cause);
    endtask

    task automatic test_sw_at_hold_end();
        sw = 1'b1;
        clear_rec();
        step();
        sw = 1'b0;
        run(64);
        sw = 1'b1;
        step();
        sw = 1'b0;
        n_cmp++; if (stage !== 3'b000) begin n_err++; $display("FAIL hold_abort_stage: got %b expected 000", stage); end
        n_cmp++; if (cause !== 3'b100) begin n_err++; $display("FAIL hold_abort_cause: got %b expected 100", cause); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_abort_busy: got %b expected 1", busy); end
        run(80);
        n_cmp++; if (rise_at[0] != 131) begin n_err++; $display("FAIL hold_restart_stage0: got %0d expected 131", rise_at[0]); end
        $display("test_sw_at_hold_end: stage0 rise=%0d cause=%b", rise_at[0], cause);
    endtask

    task automatic test_async_reset();
        sw = 1'b1;
        clear_rec();
        step();
        sw = 1'b0;
        for (int i = 0; i < 100 && !stage[0]; i++) step();
        run(3);
        n_cmp++; if (stage !== 3'b001) begin n_err++; $display("FAIL async_pre_stage: got %b expected 001", stage); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (stage !== 3'b000) begin n_err++; $display("FAIL async_stage: got %b expected 000", stage); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL async_busy: got %b expected 1", busy); end
        n_cmp++; if (cause !== 3'b000) begin n_err++; $display("FAIL async_cause: got %b expected 000", cause); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_rec();
        run(110);
        n_cmp++; if (rise_at[0] != 83) begin n_err++; $display("FAIL post_async_stage0: got %0d expected 83", rise_at[0]); end
        n_cmp++; if (rise_at[2] != 99) begin n_err++; $display("FAIL post_async_stage2: got %0d expected 99", rise_at[2]); end
        $display("test_async_reset: post-reset rise0=%0d rise2=%0d", rise_at[0], rise_at[2]);
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_sw_reset();
        test_glitch();
        test_ext_reset();
        test_pll_drop();
        test_sw_at_hold_end();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
